// File: rtl/cla_multiword_sequencer_if.sv
// Operand/result handshake and adder-side bus for cla_multiword_sequencer.
// The slave modport is the sequencer; the master is whoever drives operands and hosts the adder.
interface cla_multiword_sequencer_if #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) ();
  localparam int unsigned TW = WORD_W * NUM_WORDS;

  logic              In_Valid;
  logic              In_Ready;
  logic [TW-1:0]     A_In;
  logic [TW-1:0]     B_In;
  logic              C_In;
  logic [WORD_W-1:0] Add_A_Out;
  logic [WORD_W-1:0] Add_B_Out;
  logic              Add_C_Out;
  logic [WORD_W-1:0] Add_Sum_In;
  logic              Add_Cy_In;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [TW-1:0]     Sum_Out;
  logic              C_Out;

  modport master (
    output In_Valid, A_In, B_In, C_In, Add_Sum_In, Add_Cy_In, Out_Ready,
    input  In_Ready, Add_A_Out, Add_B_Out, Add_C_Out, Out_Valid, Sum_Out, C_Out
  );

  modport slave (
    input  In_Valid, A_In, B_In, C_In, Add_Sum_In, Add_Cy_In, Out_Ready,
    output In_Ready, Add_A_Out, Add_B_Out, Add_C_Out, Out_Valid, Sum_Out, C_Out
  );
endinterface

// File: rtl/cla_multiword_sequencer.sv
// Sequences a wide addition through an external WORD_W-bit adder, one word per cycle, LSW first.
// The inter-word carry lives only in carry_q; the result is held in DONE until taken.
module cla_multiword_sequencer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) (
  input logic                     Clk_In,
  input logic                     Rst_N_In,
  cla_multiword_sequencer_if.slave bus
);
  localparam int unsigned TW    = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned SEL_W = $clog2(TW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [TW-1:0]    a_q, a_d;
  logic [TW-1:0]    b_q, b_d;
  logic [TW-1:0]    sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [SEL_W-1:0] lo_c;
  logic             run_c;

  assign lo_c  = SEL_W'(idx_q) * SEL_W'(WORD_W);
  assign run_c = (state_q == S_RUN);

  // Adder is driven only while a word is in flight; quiet otherwise.
  assign bus.In_Ready  = (state_q == S_IDLE);
  assign bus.Out_Valid = (state_q == S_DONE);
  assign bus.Add_A_Out = run_c ? a_q[lo_c +: WORD_W] : '0;
  assign bus.Add_B_Out = run_c ? b_q[lo_c +: WORD_W] : '0;
  assign bus.Add_C_Out = run_c & carry_q;
  assign bus.Sum_Out   = sum_q;
  assign bus.C_Out     = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.In_Valid) begin
          a_d     = bus.A_In;
          b_d     = bus.B_In;
          carry_d = bus.C_In;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[lo_c +: WORD_W] = bus.Add_Sum_In;
        carry_d               = bus.Add_Cy_In;
        idx_d                 = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = bus.Add_Cy_In;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.Out_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Rst_N_In) begin
    if (!Rst_N_In) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule
